// File: rtl/cpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs_pkg
// Shared CPU definitions used by the fetch unit and the instruction decoder.
//   - PCSRC_* : next-PC source selection driven by the decoder
//   - fetch_state_e : fetch unit FSM states
//   - WORD_BYTES : instruction word size in bytes
//   - is_word_aligned() : true when a byte address is word aligned
// ---------------------------------------------------------------------------
package cpu_defs_pkg;

    localparam int WORD_BYTES = 4;

    localparam logic [1:0] PCSRC_SEQ  = 2'd0;
    localparam logic [1:0] PCSRC_REG  = 2'd1;
    localparam logic [1:0] PCSRC_JABS = 2'd2;
    localparam logic [1:0] PCSRC_BR   = 2'd3;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Bundles the instruction-memory handshake and the decoder/datapath signals
// seen by the fetch unit.
//   imemReq/imemAddr        : fetch request and byte address
//   imemAck/imemData        : memory response
//   instruction/instrValid  : held instruction for the decoder
//   pcPlus4                 : PC of held instruction + 4 (jal link)
//   advance/pcSrc/regTarget/branchTaken : execute-complete and next-PC info
//   fault                   : sticky misaligned-target fault
// Modports: master = fetch unit, slave = memory + datapath side.
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;

    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic [31:0] instruction;
    logic        instrValid;
    logic [31:0] pcPlus4;
    logic        advance;
    logic [1:0]  pcSrc;
    logic [31:0] regTarget;
    logic        branchTaken;
    logic        fault;

    modport master (
        output imemReq, imemAddr, instruction, instrValid, pcPlus4, fault,
        input  imemAck, imemData, advance, pcSrc, regTarget, branchTaken
    );

    modport slave (
        input  imemReq, imemAddr, instruction, instrValid, pcPlus4, fault,
        output imemAck, imemData, advance, pcSrc, regTarget, branchTaken
    );

endinterface

// File: rtl/instruction_fetch_unit_next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc
// Combinational next-PC selection for the held instruction.
//   pc_i           : PC of the held instruction
//   instruction_i  : held instruction word (jump index / branch offset)
//   pc_src_i       : PCSRC_* selection
//   reg_target_i   : rs value for register-indirect jumps
//   branch_taken_i : branch outcome (only for PCSRC_BR)
//   next_pc_o      : selected next PC
//   misaligned_o   : next_pc_o is not word aligned
// ---------------------------------------------------------------------------
module next_pc_calc
    import cpu_defs_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] instruction_i,
    input  logic [1:0]  pc_src_i,
    input  logic [31:0] reg_target_i,
    input  logic        branch_taken_i,
    output logic [31:0] next_pc_o,
    output logic        misaligned_o
);

    logic        [31:0] pc_plus4;
    logic signed [31:0] br_off;

    always_comb begin
        pc_plus4 = pc_i + 32'(WORD_BYTES);
        // Sign-extended word offset, already scaled to bytes.
        br_off   = {{14{instruction_i[15]}}, instruction_i[15:0], 2'b00};

        next_pc_o = pc_plus4;
        case (pc_src_i)
            PCSRC_SEQ:  next_pc_o = pc_plus4;
            PCSRC_REG:  next_pc_o = reg_target_i;
            PCSRC_JABS: next_pc_o = {pc_plus4[31:28], instruction_i[25:0], 2'b00};
            PCSRC_BR:   next_pc_o = branch_taken_i ? (pc_plus4 + $unsigned(br_off))
                                                   : pc_plus4;
            default:    next_pc_o = pc_plus4;
        endcase

        misaligned_o = !is_word_aligned(next_pc_o);
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Owns the PC, fetches one instruction word over a req/ack handshake, holds
// it for the decoder until the datapath advances, then moves to the next PC.
//   clk   : system clock, all logic on posedge
//   reset : synchronous active-high reset
//   bus   : instruction_fetch_unit_if.master (memory + decoder signals)
// Parameter RESET_PC: word-aligned PC loaded on reset.
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    instruction_fetch_unit_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         vld_q, vld_d;
    logic         req_q, req_d;
    logic         fault_q, fault_d;

    logic [31:0]  next_pc;
    logic         next_misaligned;

    next_pc_calc u_next_pc_calc (
        .pc_i           (pc_q),
        .instruction_i  (instr_q),
        .pc_src_i       (bus.pcSrc),
        .reg_target_i   (bus.regTarget),
        .branch_taken_i (bus.branchTaken),
        .next_pc_o      (next_pc),
        .misaligned_o   (next_misaligned)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        req_d   = req_q;
        fault_d = fault_q;

        case (state_q)
            FETCH: begin
                // Request is registered: it rises one cycle after entering
                // FETCH (after reset or after an advance), giving the bubble.
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (bus.imemAck) begin
                    instr_d = bus.imemData;
                    vld_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.advance) begin
                    vld_d = 1'b0;
                    if (next_misaligned) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
            end
            FAULT: begin
                vld_d   = 1'b0;
                req_d   = 1'b0;
                fault_d = 1'b1;
            end
            default: begin
                req_d   = 1'b0;
                vld_d   = 1'b0;
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            vld_q   <= 1'b0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    assign bus.imemReq     = req_q;
    assign bus.imemAddr    = pc_q;
    assign bus.instruction = instr_q;
    assign bus.instrValid  = vld_q;
    assign bus.pcPlus4     = pc_q + 32'(WORD_BYTES);
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed-vector bench for instruction_fetch_unit. Inputs are driven and
// outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;
    import cpu_defs_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic adv(input logic [1:0] src, input logic [31:0] tgt, input logic taken);
        bus.advance     = 1'b1;
        bus.pcSrc       = src;
        bus.regTarget   = tgt;
        bus.branchTaken = taken;
        tick();
        bus.advance     = 1'b0;
        bus.branchTaken = 1'b0;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int n = 0;
        while (!bus.imemReq && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(bus.imemReq), 32'd1);
        chk({tag, "_addr"}, bus.imemAddr, exp_addr);
    endtask

    task automatic ack_with(input string tag, input logic [31:0] data);
        bus.imemAck  = 1'b1;
        bus.imemData = data;
        tick();
        bus.imemAck  = 1'b0;
        chk({tag, "_vld"}, 32'(bus.instrValid), 32'd1);
        chk({tag, "_instr"}, bus.instruction, data);
    endtask

    initial begin
        reset           = 1'b1;
        bus.imemAck     = 1'b0;
        bus.imemData    = '0;
        bus.advance     = 1'b0;
        bus.pcSrc       = PCSRC_SEQ;
        bus.regTarget   = '0;
        bus.branchTaken = 1'b0;

        // Reset state
        @(negedge clk);
        tick();
        chk("rst_req",   32'(bus.imemReq),    32'd0);
        chk("rst_vld",   32'(bus.instrValid), 32'd0);
        chk("rst_instr", bus.instruction,     32'd0);
        chk("rst_fault", 32'(bus.fault),      32'd0);
        reset = 1'b0;
        tick();

        // First fetch: two wait cycles, ack on the third request cycle
        for (int i = 0; i < 3; i++) begin
            chk("t1_req",  32'(bus.imemReq), 32'd1);
            chk("t1_addr", bus.imemAddr,     32'h0);
            if (i == 2) begin
                bus.imemAck  = 1'b1;
                bus.imemData = 32'h2008_0005;
            end
            tick();
        end
        bus.imemAck = 1'b0;
        chk("t1_vld",   32'(bus.instrValid), 32'd1);
        chk("t1_instr", bus.instruction,     32'h2008_0005);
        chk("t1_pc4",   bus.pcPlus4,         32'h4);
        chk("t1_reqlo", 32'(bus.imemReq),    32'd0);

        // Spurious ack in HOLD is dropped
        bus.imemAck  = 1'b1;
        bus.imemData = 32'hDEAD_BEEF;
        tick();
        bus.imemAck = 1'b0;
        chk("spur_instr", bus.instruction,     32'h2008_0005);
        chk("spur_vld",   32'(bus.instrValid), 32'd1);
        chk("spur_req",   32'(bus.imemReq),    32'd0);

        // Sequential advance: bubble, then request at 4
        adv(PCSRC_SEQ, 32'h0, 1'b0);
        chk("seq_bub_vld", 32'(bus.instrValid), 32'd0);
        chk("seq_bub_req", 32'(bus.imemReq),    32'd0);
        wait_req("seq", 32'h4);
        ack_with("seq", 32'h0000_0020);
        chk("seq_pc4", bus.pcPlus4, 32'h8);

        // Absolute jump from 0x0040_0010
        adv(PCSRC_REG, 32'h0040_0010, 1'b0);
        wait_req("jset", 32'h0040_0010);
        ack_with("jset", 32'h0810_0008);
        chk("j_pc4", bus.pcPlus4, 32'h0040_0014);
        adv(PCSRC_JABS, 32'h0, 1'b0);
        wait_req("jabs", 32'h0040_0020);
        ack_with("jabs", 32'h0);

        // Branch taken, imm = -2 at pc 0x100
        adv(PCSRC_REG, 32'h100, 1'b0);
        wait_req("bset1", 32'h100);
        ack_with("bset1", 32'h1000_FFFE);
        adv(PCSRC_BR, 32'h0, 1'b1);
        wait_req("btaken", 32'hFC);
        ack_with("btaken", 32'h1000_FFFE);

        // Branch not taken at pc 0x100
        adv(PCSRC_REG, 32'h100, 1'b0);
        wait_req("bset2", 32'h100);
        ack_with("bset2", 32'h1000_FFFE);
        adv(PCSRC_BR, 32'h0, 1'b0);
        wait_req("bnot", 32'h104);
        ack_with("bnot", 32'h0);

        // PC wrap at the top of the address space
        adv(PCSRC_REG, 32'hFFFF_FFFC, 1'b0);
        wait_req("wset", 32'hFFFF_FFFC);
        ack_with("wset", 32'h0);
        chk("wrap_pc4", bus.pcPlus4, 32'h0);
        adv(PCSRC_SEQ, 32'h0, 1'b0);
        wait_req("wrap", 32'h0);
        ack_with("wrap", 32'h0);

        // Misaligned jr target faults and stays faulted
        adv(PCSRC_REG, 32'h0000_0102, 1'b0);
        chk("flt_fault", 32'(bus.fault),      32'd1);
        chk("flt_vld",   32'(bus.instrValid), 32'd0);
        chk("flt_req",   32'(bus.imemReq),    32'd0);
        chk("flt_pc",    bus.imemAddr,        32'h0);
        bus.advance   = 1'b1;
        bus.pcSrc     = PCSRC_SEQ;
        bus.imemAck   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flt_stk_fault", 32'(bus.fault),      32'd1);
            chk("flt_stk_req",   32'(bus.imemReq),    32'd0);
            chk("flt_stk_vld",   32'(bus.instrValid), 32'd0);
        end
        bus.advance = 1'b0;
        bus.imemAck = 1'b0;

        // Reset pulse clears the fault and refetches at RESET_PC
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("clr_fault", 32'(bus.fault), 32'd0);
        wait_req("refetch", RST_PC);
        ack_with("refetch", 32'h1111_1111);

        // Reset in the middle of a wait at 0x40
        adv(PCSRC_REG, 32'h40, 1'b0);
        wait_req("mid", 32'h40);
        tick();
        chk("mid_hold_req",  32'(bus.imemReq), 32'd1);
        chk("mid_hold_addr", bus.imemAddr,     32'h40);
        reset = 1'b1;
        tick();
        chk("mid_rst_req", 32'(bus.imemReq), 32'd0);
        bus.imemAck  = 1'b1;
        bus.imemData = 32'hCAFE_F00D;
        tick();
        bus.imemAck = 1'b0;
        chk("mid_late_vld", 32'(bus.instrValid), 32'd0);
        chk("mid_late_req", 32'(bus.imemReq),    32'd0);
        reset = 1'b0;
        tick();
        chk("mid_restart_req",  32'(bus.imemReq), 32'd1);
        chk("mid_restart_addr", bus.imemAddr,     RST_PC);
        chk("mid_restart_vld",  32'(bus.instrValid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
